// File: rtl/player_action.sv
// Player-side melee/camouflage controller: frame-tick driven attack and camo FSMs,
// grace-timed game-over detection and a saturating kill counter for the HUD.
module player_action #(
  parameter logic [7:0]  KEY_ATTACK     = 8'h0D,
  parameter logic [7:0]  KEY_CAMO       = 8'h0E,
  parameter int unsigned WINDUP_FRAMES  = 4,
  parameter int unsigned ACTIVE_FRAMES  = 6,
  parameter int unsigned RECOVER_FRAMES = 10,
  parameter int unsigned CAMO_FRAMES    = 180,
  parameter int unsigned COOL_FRAMES    = 300,
  parameter int unsigned GRACE_FRAMES   = 30
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic [7:0] keycode,
  input  logic       detect,
  input  logic       enemy1_alive,
  output logic       hit,
  output logic       camo,
  output logic       attack_busy,
  output logic       camo_ready,
  output logic [8:0] camo_frames,
  output logic       alert,
  output logic       game_over,
  output logic [3:0] kill_count
);

  typedef enum logic [1:0] {AtkIdle, AtkWindup, AtkActive, AtkRecover} atk_e;
  typedef enum logic [1:0] {CamoReady, CamoOn, CamoCool} camo_e;

  atk_e        atk_q, atk_d;
  camo_e       cst_q, cst_d;
  logic [5:0]  acnt_q, acnt_d;
  logic [8:0]  ccnt_q, ccnt_d;
  logic [5:0]  gcnt_q, gcnt_d;
  logic        go_q, go_d;
  logic [3:0]  kill_q, kill_d;
  logic        fd_q, tick_q;
  logic        atk_prev_q, cam_prev_q, alive_q;
  logic        hit_q, camo_q, busy_q, ready_q, alert_q;
  logic [8:0]  frames_q;

  logic atk_now, cam_now, atk_go, cam_go, grace;

  assign atk_now = (keycode == KEY_ATTACK);
  assign cam_now = (keycode == KEY_CAMO);
  // Attack has priority over a simultaneous camo press.
  assign atk_go  = atk_now & ~atk_prev_q & ~go_q & (atk_q == AtkIdle);
  assign cam_go  = cam_now & ~cam_prev_q & ~go_q & (cst_q == CamoReady) & ~atk_go;
  assign grace   = detect & enemy1_alive & ~go_q;

  always_comb begin
    atk_d  = atk_q;
    acnt_d = acnt_q;
    cst_d  = cst_q;
    ccnt_d = ccnt_q;
    kill_d = kill_q;
    gcnt_d = grace ? gcnt_q + 6'd1 : 6'd0;
    go_d   = go_q | (grace & (gcnt_q == 6'(GRACE_FRAMES - 1)));
    if (go_q) begin
      atk_d  = AtkIdle;
      acnt_d = '0;
      cst_d  = CamoReady;
      ccnt_d = '0;
    end else begin
      unique case (atk_q)
        AtkIdle: begin
          if (atk_go) begin
            atk_d  = AtkWindup;
            acnt_d = 6'(WINDUP_FRAMES - 1);
          end
        end
        AtkWindup: begin
          if (acnt_q == '0) begin
            atk_d  = AtkActive;
            acnt_d = 6'(ACTIVE_FRAMES - 1);
          end else acnt_d = acnt_q - 6'd1;
        end
        AtkActive: begin
          if (acnt_q == '0) begin
            atk_d  = AtkRecover;
            acnt_d = 6'(RECOVER_FRAMES - 1);
          end else acnt_d = acnt_q - 6'd1;
        end
        AtkRecover: begin
          if (acnt_q == '0) atk_d = AtkIdle;
          else acnt_d = acnt_q - 6'd1;
        end
      endcase

      unique case (cst_q)
        CamoReady: begin
          if (cam_go) begin
            cst_d  = CamoOn;
            ccnt_d = 9'(CAMO_FRAMES - 1);
          end
        end
        CamoOn: begin
          // Attacking breaks camouflage straight into cooldown.
          if (atk_go || ccnt_q == '0) begin
            cst_d  = CamoCool;
            ccnt_d = 9'(COOL_FRAMES - 1);
          end else ccnt_d = ccnt_q - 9'd1;
        end
        CamoCool: begin
          if (ccnt_q == '0) cst_d = CamoReady;
          else ccnt_d = ccnt_q - 9'd1;
        end
        default: begin
          cst_d  = CamoReady;
          ccnt_d = '0;
        end
      endcase

      if (alive_q && !enemy1_alive && (atk_q == AtkActive || atk_q == AtkRecover) &&
          kill_q != 4'hF) begin
        kill_d = kill_q + 4'd1;
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      atk_q      <= AtkIdle;
      cst_q      <= CamoReady;
      acnt_q     <= '0;
      ccnt_q     <= '0;
      gcnt_q     <= '0;
      go_q       <= 1'b0;
      kill_q     <= '0;
      fd_q       <= 1'b0;
      tick_q     <= 1'b0;
      atk_prev_q <= 1'b0;
      cam_prev_q <= 1'b0;
      alive_q    <= 1'b0;
      hit_q      <= 1'b0;
      camo_q     <= 1'b0;
      busy_q     <= 1'b0;
      ready_q    <= 1'b1;
      frames_q   <= '0;
      alert_q    <= 1'b0;
    end else begin
      fd_q    <= frame_clk;
      tick_q  <= frame_clk & ~fd_q;
      alert_q <= detect;
      if (tick_q) begin
        atk_q      <= atk_d;
        cst_q      <= cst_d;
        acnt_q     <= acnt_d;
        ccnt_q     <= ccnt_d;
        gcnt_q     <= gcnt_d;
        go_q       <= go_d;
        kill_q     <= kill_d;
        atk_prev_q <= atk_now;
        cam_prev_q <= cam_now;
        alive_q    <= enemy1_alive;
        // Status outputs present the state held during the previous frame.
        hit_q      <= (atk_q == AtkActive) & ~go_q;
        camo_q     <= (cst_q == CamoOn) & ~go_q;
        busy_q     <= (atk_q != AtkIdle);
        ready_q    <= (cst_q == CamoReady);
        frames_q   <= ccnt_q;
      end
    end
  end

  assign hit         = hit_q & ~go_q;
  assign camo        = camo_q & ~go_q;
  assign attack_busy = busy_q;
  assign camo_ready  = ready_q;
  assign camo_frames = frames_q;
  assign alert       = alert_q;
  assign game_over   = go_q;
  assign kill_count  = kill_q;

endmodule

// File: tb/tb_player_action.sv
// Scoreboard bench for player_action: expected outputs are queued per frame and
// drained against the DUT once that frame's tick has been processed.
module tb_player_action;

  localparam logic [7:0] KA = 8'h0D;
  localparam logic [7:0] KC = 8'h0E;

  localparam int SHit = 0, SCamo = 1, SBusy = 2, SReady = 3, SFrames = 4, SGo = 5,
                 SKills = 6, SAlert = 7;

  logic       Clk = 1'b0;
  logic       Reset = 1'b0;
  logic       frame_clk = 1'b0;
  logic [7:0] keycode = 8'h00;
  logic       detect = 1'b0;
  logic       enemy1_alive = 1'b1;
  logic       hit, camo, attack_busy, camo_ready, alert, game_over;
  logic [8:0] camo_frames;
  logic [3:0] kill_count;

  typedef struct {
    int          sig;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  player_action dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .frame_clk    (frame_clk),
    .keycode      (keycode),
    .detect       (detect),
    .enemy1_alive (enemy1_alive),
    .hit          (hit),
    .camo         (camo),
    .attack_busy  (attack_busy),
    .camo_ready   (camo_ready),
    .camo_frames  (camo_frames),
    .alert        (alert),
    .game_over    (game_over),
    .kill_count   (kill_count)
  );

  always #10 Clk = ~Clk;

  function automatic logic [31:0] obs(int sig);
    case (sig)
      SHit:    return {31'd0, hit};
      SCamo:   return {31'd0, camo};
      SBusy:   return {31'd0, attack_busy};
      SReady:  return {31'd0, camo_ready};
      SFrames: return {23'd0, camo_frames};
      SGo:     return {31'd0, game_over};
      SKills:  return {28'd0, kill_count};
      SAlert:  return {31'd0, alert};
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  function automatic string sig_name(int sig);
    case (sig)
      SHit:    return "hit";
      SCamo:   return "camo";
      SBusy:   return "attack_busy";
      SReady:  return "camo_ready";
      SFrames: return "camo_frames";
      SGo:     return "game_over";
      SKills:  return "kill_count";
      SAlert:  return "alert";
      default: return "unknown";
    endcase
  endfunction

  task automatic expect_sig(int sig, int val);
    exp_t e;
    e.sig = sig;
    e.val = 32'(val);
    sb.push_back(e);
  endtask

  // One frame strobe; returns just after the tick cycle's update edge.
  task automatic frame_tick();
    @(negedge Clk);
    frame_clk = 1'b1;
    @(negedge Clk);
    @(negedge Clk);
    frame_clk = 1'b0;
  endtask

  task automatic do_reset();
    keycode      = 8'h00;
    detect       = 1'b0;
    enemy1_alive = 1'b1;
    frame_clk    = 1'b0;
    Reset        = 1'b0;
    repeat (3) @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
  endtask

  task automatic test_reset();
    exp_t e;
    do_reset();
    expect_sig(SHit, 0);
    expect_sig(SCamo, 0);
    expect_sig(SBusy, 0);
    expect_sig(SReady, 1);
    expect_sig(SFrames, 0);
    expect_sig(SGo, 0);
    expect_sig(SKills, 0);
    expect_sig(SAlert, 0);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (obs(e.sig) !== e.val) begin
        errors++;
        $display("FAIL reset %s got=%0d exp=%0d", sig_name(e.sig), obs(e.sig), e.val);
      end
    end
  endtask

  task automatic test_attack();
    exp_t e;
    do_reset();
    for (int k = 1; k <= 36; k++) begin
      keycode = ((k <= 23) || (k == 25) || (k == 26)) ? KA : 8'h00;
      expect_sig(SHit, ((k >= 6 && k <= 11) || (k >= 30 && k <= 35)) ? 1 : 0);
      expect_sig(SBusy, ((k >= 2 && k <= 21) || (k >= 26)) ? 1 : 0);
      frame_tick();
      while (sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if (obs(e.sig) !== e.val) begin
          errors++;
          $display("FAIL attack %s tick=%0d got=%0d exp=%0d", sig_name(e.sig), k,
                   obs(e.sig), e.val);
        end
      end
    end
  endtask

  task automatic test_camo();
    exp_t e;
    int   fr;
    do_reset();
    for (int k = 1; k <= 484; k++) begin
      keycode = (k == 1 || k == 100) ? KC : 8'h00;
      if (k >= 2 && k <= 181) fr = 181 - k;
      else if (k >= 182 && k <= 481) fr = 481 - k;
      else fr = 0;
      expect_sig(SCamo, (k >= 2 && k <= 181) ? 1 : 0);
      expect_sig(SReady, (k == 1 || k >= 482) ? 1 : 0);
      expect_sig(SFrames, fr);
      frame_tick();
      while (sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if (obs(e.sig) !== e.val) begin
          errors++;
          $display("FAIL camo %s tick=%0d got=%0d exp=%0d", sig_name(e.sig), k,
                   obs(e.sig), e.val);
        end
      end
    end
  endtask

  task automatic test_camo_break();
    exp_t e;
    do_reset();
    for (int k = 1; k <= 32; k++) begin
      keycode = (k == 1) ? KC : ((k == 20) ? KA : 8'h00);
      expect_sig(SCamo, (k >= 2 && k <= 20) ? 1 : 0);
      expect_sig(SFrames, (k == 1) ? 0 : ((k <= 20) ? 181 - k : 320 - k));
      expect_sig(SHit, (k >= 25 && k <= 30) ? 1 : 0);
      frame_tick();
      while (sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if (obs(e.sig) !== e.val) begin
          errors++;
          $display("FAIL camo_break %s tick=%0d got=%0d exp=%0d", sig_name(e.sig), k,
                   obs(e.sig), e.val);
        end
      end
    end
  endtask

  task automatic test_game_over();
    exp_t e;
    do_reset();
    detect       = 1'b1;
    enemy1_alive = 1'b1;
    for (int k = 1; k <= 45; k++) begin
      keycode = (k == 35) ? KA : 8'h00;
      expect_sig(SGo, (k >= 30) ? 1 : 0);
      expect_sig(SHit, 0);
      expect_sig(SBusy, 0);
      expect_sig(SAlert, 1);
      frame_tick();
      while (sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if (obs(e.sig) !== e.val) begin
          errors++;
          $display("FAIL game_over %s tick=%0d got=%0d exp=%0d", sig_name(e.sig), k,
                   obs(e.sig), e.val);
        end
      end
    end
  endtask

  task automatic test_grace_cancel();
    exp_t e;
    do_reset();
    detect = 1'b1;
    for (int k = 1; k <= 72; k++) begin
      enemy1_alive = (k >= 15 && k <= 40) ? 1'b0 : 1'b1;
      // Counting restarts at tick 41, so the loss lands 29 ticks later.
      expect_sig(SGo, (k >= 70) ? 1 : 0);
      frame_tick();
      while (sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if (obs(e.sig) !== e.val) begin
          errors++;
          $display("FAIL grace_cancel %s tick=%0d got=%0d exp=%0d", sig_name(e.sig), k,
                   obs(e.sig), e.val);
        end
      end
    end
  endtask

  task automatic test_kill_count();
    exp_t e;
    do_reset();
    for (int k = 1; k <= 28; k++) begin
      keycode      = (k == 1) ? KA : 8'h00;
      enemy1_alive = (k >= 7 && k <= 24) ? 1'b0 : ((k >= 27) ? 1'b0 : 1'b1);
      expect_sig(SKills, (k >= 7) ? 1 : 0);
      frame_tick();
      while (sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if (obs(e.sig) !== e.val) begin
          errors++;
          $display("FAIL kill_active %s tick=%0d got=%0d exp=%0d", sig_name(e.sig), k,
                   obs(e.sig), e.val);
        end
      end
    end
    for (int r = 1; r <= 16; r++) begin
      for (int t = 0; t <= 21; t++) begin
        keycode      = (t == 0) ? KA : 8'h00;
        enemy1_alive = (t < 6) ? 1'b1 : 1'b0;
        frame_tick();
      end
      expect_sig(SKills, (r + 1 > 15) ? 15 : r + 1);
      while (sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if (obs(e.sig) !== e.val) begin
          errors++;
          $display("FAIL kill_saturate %s round=%0d got=%0d exp=%0d", sig_name(e.sig), r,
                   obs(e.sig), e.val);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    exp_t e;
    do_reset();
    for (int k = 1; k <= 7; k++) begin
      keycode      = (k == 1) ? KA : ((k == 2) ? KC : 8'h00);
      enemy1_alive = (k == 7) ? 1'b0 : 1'b1;
      frame_tick();
    end
    expect_sig(SHit, 1);
    expect_sig(SCamo, 1);
    expect_sig(SReady, 0);
    expect_sig(SKills, 1);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (obs(e.sig) !== e.val) begin
        errors++;
        $display("FAIL async_pre %s got=%0d exp=%0d", sig_name(e.sig), obs(e.sig), e.val);
      end
    end
    @(posedge Clk);
    #3 Reset = 1'b0;
    expect_sig(SHit, 0);
    expect_sig(SCamo, 0);
    expect_sig(SReady, 1);
    expect_sig(SKills, 0);
    expect_sig(SBusy, 0);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (obs(e.sig) !== e.val) begin
        errors++;
        $display("FAIL async_reset %s got=%0d exp=%0d", sig_name(e.sig), obs(e.sig), e.val);
      end
    end
    repeat (2) @(negedge Clk);
    Reset = 1'b1;
  endtask

  initial begin
    test_reset();
    test_attack();
    test_camo();
    test_camo_break();
    test_game_over();
    test_grace_cancel();
    test_kill_count();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
